mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 33 +++
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder_byte_fifo.sv | 53 +++++
 rtl/mem_responder.sv | 99 +++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared address map, status-bit layout and decode helpers for the memory responder.
package mem_responder_pkg;

  localparam logic [1:0]  IO_SEL           = 2'b11;
  localparam logic [31:0] IO_DATA_ADDR     = 32'h0003_0000;
  localparam logic [31:0] IO_STAT_ADDR     = 32'h0003_0004;
  localparam int          STAT_TX_FULL_BIT = 0;
  localparam int          STAT_RX_NE_BIT   = 1;

  typedef enum logic [1:0] {
    ACC_RAM,
    ACC_IO_DATA,
    ACC_IO_STAT,
    ACC_IO_NONE
  } acc_e;

  // Only bits [17:16] pick the I/O window; the low half names the register.
  function automatic acc_e decode_addr(input logic [17:0] a);
    if (a[17:16] != IO_SEL)                 return ACC_RAM;
    else if (a[15:0] == IO_DATA_ADDR[15:0]) return ACC_IO_DATA;
    else if (a[15:0] == IO_STAT_ADDR[15:0]) return ACC_IO_STAT;
    else                                    return ACC_IO_NONE;
  endfunction

  function automatic logic [7:0] status_byte(input logic rx_nonempty, input logic tx_full);
    logic [7:0] s;
    s                   = '0;
    s[STAT_RX_NE_BIT]   = rx_nonempty;
    s[STAT_TX_FULL_BIT] = tx_full;
    return s;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Controller bus plus TX/RX byte streams of the memory responder.
interface mem_responder_if;
  logic        rdy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output rdy, mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    input  mem_din, io_full, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  rdy, mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    output mem_din, io_full, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/mem_responder_byte_fifo.sv
// Byte FIFO with first-word fall-through head; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide RAM plus memory-mapped TX/RX FIFOs answering a CPU memory controller
// with a registered one-cycle read path.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  acc_e              acc;
  logic              cpu_en;
  logic [ADDR_W-1:0] ram_a;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0]     tx_count, rx_count;
  logic [7:0]        rx_head;
  logic [7:0]        io_rd;
  logic              unused_bits;

  assign acc         = decode_addr(bus.mem_a[17:0]);
  assign cpu_en      = bus.rdy && rst_n;
  assign ram_a       = bus.mem_a[ADDR_W-1:0];
  assign unused_bits = ^{bus.mem_a[31:18], rx_count};

  assign tx_push = cpu_en && bus.mem_wr && (acc == ACC_IO_DATA);
  assign tx_pop  = bus.tx_valid && bus.tx_ready;
  assign rx_push = bus.rx_valid && bus.rx_ready;
  assign rx_pop  = cpu_en && !bus.mem_wr && (acc == ACC_IO_DATA) && !rx_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus.mem_dout),
    .dout  (bus.tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (bus.rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign bus.io_full  = (tx_count == CW'(FIFO_DEPTH));
  assign bus.tx_valid = !tx_empty;
  assign bus.rx_ready = !rx_full;

  always_comb begin
    io_rd = 8'h00;
    case (acc)
      ACC_IO_DATA: io_rd = rx_empty ? 8'h00 : rx_head;
      ACC_IO_STAT: io_rd = status_byte(!rx_empty, tx_full);
      default:     io_rd = 8'h00;
    endcase
  end

  // ---- p0 -> p1: RAM array kept reset-free so it can map onto block RAM ----
  logic [7:0] ram [2**ADDR_W];
  logic [7:0] ram_rd_p1;
  logic [7:0] io_rd_p1;
  logic       ram_sel_p1;

  always_ff @(posedge clk) begin
    if (cpu_en && (acc == ACC_RAM)) begin
      if (bus.mem_wr) ram[ram_a] <= bus.mem_dout;
      else            ram_rd_p1  <= ram[ram_a];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_sel_p1 <= 1'b0;
      io_rd_p1   <= 8'h00;
    end else if (cpu_en && !bus.mem_wr) begin
      ram_sel_p1 <= (acc == ACC_RAM);
      io_rd_p1   <= io_rd;
    end
  end

  // ---- p1: writes and stalled cycles leave the select untouched, so mem_din holds ----
  assign bus.mem_din = ram_sel_p1 ? ram_rd_p1 : io_rd_p1;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: RAM path, TX/RX FIFOs, stall and reset.
module tb_mem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_responder_if bus();

  mem_responder #(.ADDR_W(17), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.rdy      = 1'b1;
    bus.mem_wr   = wr;
    bus.mem_a    = a;
    bus.mem_dout = d;
  endtask

  task automatic idle();
    cpu(1'b0, 32'h0000_0000, 8'h00);
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle();

    // Asynchronous reset: outputs settle without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_din",  bus.mem_din, 8'h00);
    chk("rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    chk("rst_io_full",  {7'b0, bus.io_full}, 8'h00);
    step();
    step();
    rst_n = 1'b1;

    // RAM write then read, one-cycle latency
    cpu(1'b1, 32'h0000_0100, 8'hA5);
    step();
    chk("ram_wr_hold", bus.mem_din, 8'h00);
    cpu(1'b1, 32'h0000_0101, 8'h3C);
    step();
    cpu(1'b0, 32'h0000_0100, 8'h00);
    step();
    chk("ram_rd_100", bus.mem_din, 8'hA5);
    cpu(1'b0, 32'h0000_0101, 8'h00);
    step();
    chk("ram_rd_101", bus.mem_din, 8'h3C);

    // TX fill with sink stalled, 9th write dropped
    for (int i = 1; i <= 8; i++) begin
      cpu(1'b1, 32'h0003_0000, 8'(i));
      step();
    end
    chk("tx_full_after8", {7'b0, bus.io_full}, 8'h01);
    chk("tx_head_first",  bus.tx_data, 8'h01);
    cpu(1'b1, 32'h0003_0000, 8'h09);
    step();
    chk("tx_full_after9", {7'b0, bus.io_full}, 8'h01);
    cpu(1'b0, 32'h0003_0004, 8'h00);
    step();
    chk("stat_tx_full", bus.mem_din, 8'h01);
    idle();
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("tx_drain", bus.tx_data, 8'(i));
      step();
    end
    chk("tx_empty_after_drain", {7'b0, bus.tx_valid}, 8'h00);
    chk("io_full_after_drain",  {7'b0, bus.io_full}, 8'h00);
    bus.tx_ready = 1'b0;

    // Full TX, sink pops while CPU pushes: accepted, count stays full
    for (int i = 0; i < 8; i++) begin
      cpu(1'b1, 32'h0003_0000, 8'(8'h11 + i));
      step();
    end
    bus.tx_ready = 1'b1;
    cpu(1'b1, 32'h0003_0000, 8'h19);
    step();
    chk("tx_simul_full", {7'b0, bus.io_full}, 8'h01);
    chk("tx_simul_head", bus.tx_data, 8'h12);
    idle();
    for (int i = 0; i < 8; i++) begin
      chk("tx_simul_drain", bus.tx_data, 8'(8'h12 + i));
      step();
    end
    chk("tx_simul_empty", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;

    // RX single byte: status, pop, then empty read
    chk("rx_ready_idle", {7'b0, bus.rx_ready}, 8'h01);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h41;
    step();
    bus.rx_valid = 1'b0;
    cpu(1'b0, 32'h0003_0004, 8'h00);
    step();
    chk("stat_rx_ne", bus.mem_din, 8'h02);
    cpu(1'b0, 32'h0003_0000, 8'h00);
    step();
    chk("rx_pop_41", bus.mem_din, 8'h41);
    step();
    chk("rx_pop_empty", bus.mem_din, 8'h00);
    idle();

    // RX fill to full, extra byte refused, drain in order
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = 8'(8'h50 + i);
      step();
    end
    chk("rx_ready_full", {7'b0, bus.rx_ready}, 8'h00);
    bus.rx_data = 8'h5F;
    step();
    bus.rx_valid = 1'b0;
    cpu(1'b0, 32'h0003_0000, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rx_drain", bus.mem_din, 8'(8'h50 + i));
    end
    step();
    chk("rx_drain_empty", bus.mem_din, 8'h00);
    idle();

    // Unmapped I/O address: write ignored, read returns zero
    cpu(1'b1, 32'h0003_0008, 8'hEE);
    step();
    chk("io_other_wr_no_tx", {7'b0, bus.tx_valid}, 8'h00);
    cpu(1'b0, 32'h0003_0008, 8'h00);
    step();
    chk("io_other_rd", bus.mem_din, 8'h00);

    // Stall: no RAM write, no CPU push, mem_din held, sink still drains
    cpu(1'b1, 32'h0000_0200, 8'h77);
    step();
    cpu(1'b1, 32'h0000_0200, 8'h88);
    bus.rdy = 1'b0;
    step();
    cpu(1'b0, 32'h0000_0200, 8'h00);
    step();
    chk("rdy0_ram_unchanged", bus.mem_din, 8'h77);
    cpu(1'b0, 32'h0000_0100, 8'h00);
    bus.rdy = 1'b0;
    step();
    chk("rdy0_mem_din_held", bus.mem_din, 8'h77);
    cpu(1'b1, 32'h0003_0000, 8'h99);
    bus.rdy = 1'b0;
    step();
    chk("rdy0_no_tx_push", {7'b0, bus.tx_valid}, 8'h00);
    cpu(1'b1, 32'h0003_0000, 8'h33);
    step();
    bus.rdy      = 1'b0;
    bus.tx_ready = 1'b1;
    step();
    chk("rdy0_tx_pop_runs", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;

    // Reset mid-stream with both FIFOs occupied
    for (int i = 0; i < 8; i++) begin
      cpu(1'b1, 32'h0003_0000, 8'(8'hC0 + i));
      step();
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h66;
    cpu(1'b0, 32'h0000_0100, 8'h00);
    step();
    bus.rx_valid = 1'b0;
    chk("pre_rst_mem_din", bus.mem_din, 8'hA5);
    chk("pre_rst_io_full", {7'b0, bus.io_full}, 8'h01);
    cpu(1'b1, 32'h0003_0000, 8'hDD);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_din",  bus.mem_din, 8'h00);
    chk("midrst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    chk("midrst_io_full",  {7'b0, bus.io_full}, 8'h00);
    chk("midrst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    step();
    idle();
    rst_n = 1'b1;
    step();
    chk("post_rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    cpu(1'b0, 32'h0003_0004, 8'h00);
    step();
    chk("post_rst_status", bus.mem_din, 8'h00);
    cpu(1'b0, 32'h0000_0100, 8'h00);
    step();
    chk("post_rst_ram_kept", bus.mem_din, 8'hA5);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
